// File: rtl/pbit_field_accumulator_if.sv
// Product-in / sample-out handshake bundle for the p-bit field accumulator.
// The slave side belongs to the accumulator; the master side belongs to its neighbours.
interface pbit_field_accumulator_if;
    logic [7:0] prod;
    logic       prod_valid;
    logic       prod_ready;
    logic       m;
    logic [7:0] field;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  prod,
        input  prod_valid,
        output prod_ready,
        output m,
        output field,
        output out_valid,
        input  out_ready
    );

    modport master (
        output prod,
        output prod_valid,
        input  prod_ready,
        input  m,
        input  field,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pbit_field_accumulator.sv
// Sums N_TERMS signed products, saturates to 8 bits, compares against an LFSR and emits one p-bit sample.
// Last product accepted -> one compare cycle -> sample held until out_ready; no products taken meanwhile.
module pbit_field_accumulator #(
    parameter int         N_TERMS   = 4,
    parameter int         ACC_W     = 12,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    pbit_field_accumulator_if.slave  bus
);

    localparam int                      CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0]        LAST   = CNT_W'(N_TERMS - 1);
    localparam logic [7:0]              SEED   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {
        S_ACC,
        S_CMP,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [7:0]              lfsr_q;
    logic [7:0]              lfsr_d;
    logic                    prod_ready_q;
    logic                    out_valid_q;
    logic                    m_q;
    logic [7:0]              field_q;

    logic signed [7:0]       fsat_d;
    logic                    m_d;
    logic                    take_d;
    logic                    last_d;

    always_comb begin
        take_d = (state_q == S_ACC) && bus.prod_valid;
        last_d = (cnt_q == LAST);
        acc_d  = acc_q + {{(ACC_W - 8){bus.prod[7]}}, bus.prod};

        if (acc_q > SAT_HI) begin
            fsat_d = 8'sh7F;
        end else if (acc_q < SAT_LO) begin
            fsat_d = -8'sd128;
        end else begin
            fsat_d = acc_q[7:0];
        end

        // Strict compare: a field equal to the random value yields -1.
        m_d    = fsat_d > $signed(lfsr_q);
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            prod_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            m_q          <= 1'b0;
            field_q      <= 8'h00;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (take_d) begin
                        acc_q <= acc_d;
                        if (last_d) begin
                            cnt_q        <= '0;
                            prod_ready_q <= 1'b0;
                            state_q      <= S_CMP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_CMP: begin
                    field_q     <= fsat_d;
                    m_q         <= m_d;
                    lfsr_q      <= lfsr_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        acc_q        <= '0;
                        out_valid_q  <= 1'b0;
                        prod_ready_q <= 1'b1;
                        state_q      <= S_ACC;
                    end
                end
                default: begin
                    state_q <= S_ACC;
                end
            endcase
        end
    end

    // Ready is forced low for the whole time reset is held, not just after the first edge.
    assign bus.prod_ready = prod_ready_q & ~rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.m          = m_q;
    assign bus.field      = field_q;

endmodule

// File: tb/tb_pbit_field_accumulator.sv
// Directed and randomized checks of pbit_field_accumulator against an arithmetic reference model.
module tb_pbit_field_accumulator;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   model_lfsr;

    logic [7:0] pv   [4];
    int         gaps [4];

    pbit_field_accumulator_if bus ();

    pbit_field_accumulator #(
        .N_TERMS   (4),
        .ACC_W     (12),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_sample(input int hold, input string tag);
        int         sum;
        int         sat;
        int         rnd;
        logic [7:0] f_exp;
        logic       m_exp;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                bus.prod_valid = 1'b0;
                bus.prod       = 8'h00;
                @(posedge clk); #1;
            end
            bus.prod       = pv[i];
            bus.prod_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_prod_ready"}, 32'(bus.prod_ready), 32'd1);
            @(posedge clk); #1;
            sum += int'($signed(pv[i]));
        end
        bus.prod_valid = 1'b0;

        sat   = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
        rnd   = (model_lfsr > 127) ? model_lfsr - 256 : model_lfsr;
        m_exp = (sat > rnd);
        f_exp = 8'(sat);
        model_lfsr = lfsr_next(model_lfsr);

        @(negedge clk);
        chk({tag, "_cmp_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_cmp_prod_ready"}, 32'(bus.prod_ready), 32'd0);

        @(posedge clk); #1;
        bus.out_ready = (hold == 0);
        if (hold > 0) begin
            bus.prod_valid = 1'b1;
            bus.prod       = 8'h7F;
        end
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_field"}, 32'(bus.field), 32'(f_exp));
        chk({tag, "_m"}, 32'(bus.m), 32'(m_exp));

        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            if (h == hold) begin
                bus.out_ready  = 1'b1;
                bus.prod_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_field"}, 32'(bus.field), 32'(f_exp));
            chk({tag, "_hold_m"}, 32'(bus.m), 32'(m_exp));
            chk({tag, "_hold_ready"}, 32'(bus.prod_ready), 32'd0);
        end

        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(bus.prod_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_sample(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input int ga, input int gb, input int gc, input int gd);
        pv[0] = a; pv[1] = b; pv[2] = c; pv[3] = d;
        gaps[0] = ga; gaps[1] = gb; gaps[2] = gc; gaps[3] = gd;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        model_lfsr     = 8'hA5;
        rst            = 1'b1;
        bus.prod       = 8'h00;
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b0;

        #3;
        chk("rst_m", 32'(bus.m), 32'd0);
        chk("rst_field", 32'(bus.field), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_prod_ready", 32'(bus.prod_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_prod_ready", 32'(bus.prod_ready), 32'd1);
        @(posedge clk); #1;

        set_sample(8'd10, 8'd20, 8'd30, 8'd40, 0, 0, 0, 0);
        run_sample(0, "s1_sum100");
        set_sample(8'd10, 8'd10, 8'd10, 8'd10, 0, 0, 0, 0);
        run_sample(0, "s2_sum40");
        set_sample(8'h80, 8'h80, 8'h80, 8'h80, 0, 0, 0, 0);
        run_sample(5, "s3_satneg");
        set_sample(8'd10, 8'd20, 8'd30, 8'd40, 1, 1, 1, 1);
        run_sample(0, "s4_gaps");
        set_sample(8'h7F, 8'h7F, 8'h7F, 8'h7F, 0, 2, 0, 1);
        run_sample(1, "s5_satpos");

        // Abort a partial sum with reset.
        bus.prod       = 8'd50;
        bus.prod_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.prod_valid = 1'b0;
        rst            = 1'b1;
        #1;
        chk("mid_rst_m", 32'(bus.m), 32'd0);
        chk("mid_rst_field", 32'(bus.field), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_prod_ready", 32'(bus.prod_ready), 32'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        model_lfsr = 8'hA5;
        @(negedge clk);
        chk("mid_rst_release_ready", 32'(bus.prod_ready), 32'd1);
        @(posedge clk); #1;
        set_sample(8'd10, 8'd20, 8'd30, 8'd40, 0, 0, 0, 0);
        run_sample(0, "s6_after_rst");

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                pv[i]   = 8'($urandom_range(0, 255));
                gaps[i] = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) pv[i] = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
            end
            run_sample($urandom_range(0, 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
